serial_adder: RTL

Bit-serial N-bit adder built around one instance of the team's single-bit `full_adder` cell, with ports a, b, cin, sum and cout. The block loads two WIDTH-bit operands and a carry-in and feeds the cell one bit pair per clock, LSB first. A carry flip-flop closes the loop between cycles. It presents the registered WIDTH-bit sum and carry-out with a start/busy/done handshake, trading latency for a single-cell datapath.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
//   master: drives start, a_in, b_in, cin; observes busy, done, sum_out, cout
//   slave : the adder side of the same signals
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder using a single full_adder cell, LSB first.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder_if.slave
//            start/a_in/b_in/cin sampled in IDLE; busy high in RUN/DONE;
//            done pulses one cycle with sum_out/cout, which hold until the next result
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic [WIDTH-1:0] s_sr_d;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             cout_q;
    logic             done_q;
    logic             busy_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_sr_d = fa_sum;
        end else begin : g_wn
            assign s_sr_d = {fa_sum, s_sr_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (count_q == CNT_W'(WIDTH - 1));

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr_q  <= bus.a_in;
                        b_sr_q  <= bus.b_in;
                        carry_q <= bus.cin;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_sr_q  <= s_sr_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= fa_cout;
                    count_q <= count_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q   <= s_sr_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum_out = sum_q;
    assign bus.cout    = cout_q;
endmodule

// Single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : combinational sum and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
